// File: rtl/or_mask_splitter.sv
// or_mask_splitter: takes a WIDTH-bit OR-combined mask and replays its set
// bits one per beat, lowest index first, as one-hot words with their index.
// An all-zero mask produces a single "empty" beat so the consumer always
// sees a terminating beat for every accepted mask.
module or_mask_splitter #(
  parameter int WIDTH = 32,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             out_empty
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic             r_zflag;

  logic             w_idle;
  logic             w_emit;
  logic [WIDTH-1:0] w_rem_dec;
  logic [WIDTH-1:0] w_lowbit;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_last;
  logic [IDXW-1:0]  w_index;
  logic             w_in_fire;
  logic             w_out_fire;

  // Outputs are masked off while reset is held so nothing leaks out before
  // the first reset edge has cleared the registers.
  assign w_idle = (r_state == IDLE) && !reset;
  assign w_emit = (r_state == EMIT) && !reset;

  // Lowest-set-bit isolation; all arithmetic wraps inside WIDTH bits.
  assign w_rem_dec  = r_rem - WIDTH'(1);
  assign w_lowbit   = r_rem & (~r_rem + WIDTH'(1));
  assign w_rem_next = r_rem & w_rem_dec;
  // At most one bit left (also true for an empty mask) means final beat.
  assign w_last     = (w_rem_next == '0);

  assign w_in_fire  = w_idle && in_valid;
  assign w_out_fire = w_emit && out_ready;

  // Index encoder: since w_lowbit is one-hot (or zero), index bit b is the
  // OR of every one-hot position whose own index has bit b set. A zero
  // word naturally encodes to index 0.
  logic [WIDTH-1:0] w_sel [IDXW];

  generate
    for (genvar gb = 0; gb < IDXW; gb++) begin : g_idx_bit
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pos
        if (((gi >> gb) & 1) == 1) begin : g_on
          assign w_sel[gb][gi] = w_lowbit[gi];
        end else begin : g_off
          assign w_sel[gb][gi] = 1'b0;
        end
      end
      assign w_index[gb] = |w_sel[gb];
    end
  endgenerate

  // Handshake and beat outputs, all decoded from registered state only.
  assign in_ready   = w_idle;
  assign out_valid  = w_emit;
  assign out_onehot = w_emit ? w_lowbit : '0;
  assign out_index  = w_emit ? w_index  : '0;
  assign out_last   = w_emit && w_last;
  assign out_empty  = w_emit && r_zflag;

  // Control FSM: capture a mask in IDLE, peel one bit per completed beat in
  // EMIT, and return to IDLE (with cleared state) after the final beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_zflag <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_rem   <= in_mask;
            r_zflag <= (in_mask == '0);
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_out_fire) begin
            if (w_last) begin
              r_rem   <= '0;
              r_zflag <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_rem   <= w_rem_next;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
